// File: rtl/brq_pkg.sv
// Shared types for the brq writeback stage.
package brq_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;

  // One writeback queue entry payload (valid bit kept separately).
  typedef struct packed {
    wb_instr_type_e itype;
    logic [31:0]    pc;
    logic           compressed;
    logic           count;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic           we;
    logic           fp;
  } wb_entry_t;

  // Result of a hazard/forwarding lookup for one source operand.
  typedef struct packed {
    logic        hazard;
    logic        fwd;
    logic [31:0] data;
  } wb_fwd_t;

endpackage

// File: rtl/brq_wbu_queue.sv
// In-order multi-entry writeback queue between ID/EX and the integer/FP register files,
// with per-source hazard detection and forwarding from pending entries.
module brq_wbu_queue
  import brq_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          FpEnable = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,

  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_wb_i,
  input  logic [31:0]    pc_id_i,
  input  logic           instr_is_compressed_id_i,
  input  logic           instr_perf_count_id_i,
  input  logic [4:0]     rf_waddr_id_i,
  input  logic [31:0]    rf_wdata_id_i,
  input  logic           rf_we_id_i,
  input  logic           fp_rf_we_id_i,

  input  logic           lsu_resp_valid_i,
  input  logic           lsu_resp_err_i,
  input  logic [31:0]    rf_wdata_lsu_i,

  input  logic [4:0]     rf_raddr_a_i,
  input  logic [4:0]     rf_raddr_b_i,

  output logic           ready_wb_o,
  output logic           hazard_a_o,
  output logic           hazard_b_o,
  output logic           fwd_valid_a_o,
  output logic           fwd_valid_b_o,
  output logic [31:0]    fwd_data_a_o,
  output logic [31:0]    fwd_data_b_o,
  output logic           outstanding_load_wb_o,
  output logic           outstanding_store_wb_o,

  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           rf_we_wb_o,
  output logic           fp_rf_we_wb_o,
  output logic [31:0]    pc_wb_o,

  output logic           instr_done_wb_o,
  output logic           perf_instr_ret_wb_o,
  output logic           perf_instr_ret_compressed_wb_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned SumW = PtrW + 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0] r_valid;
  wb_entry_t        r_entry [Depth];
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW-1:0]  r_wptr;
  logic [CntW-1:0]  r_count;

  wb_entry_t       w_head;
  wb_entry_t       w_new;
  logic            w_head_valid;
  logic            w_head_other;
  logic            w_head_done;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_en;
  logic [31:0]     w_wdata;
  logic [PtrW-1:0] w_rptr_nxt;
  logic [PtrW-1:0] w_wptr_nxt;
  logic            w_out_load;
  logic            w_out_store;
  wb_fwd_t         w_fwd_a;
  wb_fwd_t         w_fwd_b;

  // Head decode, retire condition and register file write data selection.
  always_comb begin
    w_head       = r_entry[r_rptr];
    w_head_valid = r_valid[r_rptr];
    w_head_other = (w_head.itype == WB_INSTR_OTHER);
    w_head_done  = w_head_valid & (w_head_other | lsu_resp_valid_i);
    w_wr_en      = 1'b0;
    w_wdata      = '0;
    if (w_head_valid) begin
      if (w_head_other) begin
        w_wr_en = w_head.we;
        w_wdata = w_head.wdata;
      end else if ((w_head.itype == WB_INSTR_LOAD) && lsu_resp_valid_i && !lsu_resp_err_i) begin
        w_wr_en = 1'b1;
        w_wdata = rf_wdata_lsu_i;
      end
    end
  end

  assign ready_wb_o = (r_count < CntW'(Depth)) | w_head_done;
  assign w_push     = en_wb_i & ready_wb_o;
  assign w_pop      = w_head_done;

  // Pointers wrap explicitly so non power-of-two depths work.
  assign w_rptr_nxt = (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
  assign w_wptr_nxt = (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);

  always_comb begin
    w_new            = '0;
    w_new.itype      = instr_type_wb_i;
    w_new.pc         = pc_id_i;
    w_new.compressed = instr_is_compressed_id_i;
    w_new.count      = instr_perf_count_id_i;
    w_new.waddr      = rf_waddr_id_i;
    w_new.wdata      = rf_wdata_id_i;
    w_new.we         = rf_we_id_i;
    w_new.fp         = fp_rf_we_id_i & FpEnable;
  end

  // Control state; a push into the slot freed by a same-cycle pop keeps it valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= w_rptr_nxt;
      end
      if (w_push) begin
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= w_wptr_nxt;
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_entry[r_wptr] <= w_new;
    end
  end

  // Walk oldest to youngest so the youngest matching entry determines the result.
  function automatic wb_fwd_t lookup(input logic [4:0] raddr);
    wb_fwd_t         res;
    logic [SumW-1:0] pos;
    logic [PtrW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      pos = SumW'(r_rptr) + SumW'(i);
      if (pos >= SumW'(Depth)) begin
        pos = pos - SumW'(Depth);
      end
      idx = pos[PtrW-1:0];
      if (r_valid[idx] && !r_entry[idx].fp &&
          (r_entry[idx].we || (r_entry[idx].itype == WB_INSTR_LOAD)) &&
          (r_entry[idx].waddr == raddr) && (raddr != 5'd0)) begin
        res = '0;
        if (r_entry[idx].itype == WB_INSTR_LOAD) begin
          res.hazard = 1'b1;
        end else if (r_entry[idx].itype == WB_INSTR_OTHER) begin
          res.fwd  = 1'b1;
          res.data = r_entry[idx].wdata;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_fwd_a = lookup(rf_raddr_a_i);
    w_fwd_b = lookup(rf_raddr_b_i);
  end

  always_comb begin
    w_out_load  = 1'b0;
    w_out_store = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (r_valid[PtrW'(i)]) begin
        w_out_load  = w_out_load  | (r_entry[PtrW'(i)].itype == WB_INSTR_LOAD);
        w_out_store = w_out_store | (r_entry[PtrW'(i)].itype == WB_INSTR_STORE);
      end
    end
  end

  assign hazard_a_o             = w_fwd_a.hazard;
  assign hazard_b_o             = w_fwd_b.hazard;
  assign fwd_valid_a_o          = w_fwd_a.fwd;
  assign fwd_valid_b_o          = w_fwd_b.fwd;
  assign fwd_data_a_o           = w_fwd_a.data;
  assign fwd_data_b_o           = w_fwd_b.data;
  assign outstanding_load_wb_o  = w_out_load;
  assign outstanding_store_wb_o = w_out_store;

  assign rf_waddr_wb_o = w_head_valid ? w_head.waddr : '0;
  assign rf_wdata_wb_o = w_wdata;
  assign rf_we_wb_o    = w_wr_en & ~w_head.fp;
  assign fp_rf_we_wb_o = w_wr_en & w_head.fp;
  assign pc_wb_o       = w_head_valid ? w_head.pc : '0;

  assign instr_done_wb_o                = w_head_done;
  assign perf_instr_ret_wb_o            = w_head_done & w_head.count &
                                          ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & w_head.compressed;

endmodule

// File: tb/tb_brq_wbu_queue.sv
// Scoreboard bench for brq_wbu_queue: directed pushes queue their expected retire records,
// a negedge monitor pops and compares on every retire.
module tb_brq_wbu_queue;
  import brq_pkg::*;

  localparam int unsigned DEPTH = 3;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           en_wb_i;
  wb_instr_type_e instr_type_wb_i;
  logic [31:0]    pc_id_i;
  logic           instr_is_compressed_id_i;
  logic           instr_perf_count_id_i;
  logic [4:0]     rf_waddr_id_i;
  logic [31:0]    rf_wdata_id_i;
  logic           rf_we_id_i;
  logic           fp_rf_we_id_i;
  logic           lsu_resp_valid_i;
  logic           lsu_resp_err_i;
  logic [31:0]    rf_wdata_lsu_i;
  logic [4:0]     rf_raddr_a_i;
  logic [4:0]     rf_raddr_b_i;
  logic           ready_wb_o;
  logic           hazard_a_o;
  logic           hazard_b_o;
  logic           fwd_valid_a_o;
  logic           fwd_valid_b_o;
  logic [31:0]    fwd_data_a_o;
  logic [31:0]    fwd_data_b_o;
  logic           outstanding_load_wb_o;
  logic           outstanding_store_wb_o;
  logic [4:0]     rf_waddr_wb_o;
  logic [31:0]    rf_wdata_wb_o;
  logic           rf_we_wb_o;
  logic           fp_rf_we_wb_o;
  logic [31:0]    pc_wb_o;
  logic           instr_done_wb_o;
  logic           perf_instr_ret_wb_o;
  logic           perf_instr_ret_compressed_wb_o;

  typedef struct packed {
    logic        we;
    logic        fpwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        perf;
    logic        perfc;
  } exp_t;

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;

  brq_wbu_queue #(.Depth(DEPTH), .FpEnable(1'b1)) dut (
    .clk_i                          (clk_i),
    .rst_ni                         (rst_ni),
    .en_wb_i                        (en_wb_i),
    .instr_type_wb_i                (instr_type_wb_i),
    .pc_id_i                        (pc_id_i),
    .instr_is_compressed_id_i       (instr_is_compressed_id_i),
    .instr_perf_count_id_i          (instr_perf_count_id_i),
    .rf_waddr_id_i                  (rf_waddr_id_i),
    .rf_wdata_id_i                  (rf_wdata_id_i),
    .rf_we_id_i                     (rf_we_id_i),
    .fp_rf_we_id_i                  (fp_rf_we_id_i),
    .lsu_resp_valid_i               (lsu_resp_valid_i),
    .lsu_resp_err_i                 (lsu_resp_err_i),
    .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
    .rf_raddr_a_i                   (rf_raddr_a_i),
    .rf_raddr_b_i                   (rf_raddr_b_i),
    .ready_wb_o                     (ready_wb_o),
    .hazard_a_o                     (hazard_a_o),
    .hazard_b_o                     (hazard_b_o),
    .fwd_valid_a_o                  (fwd_valid_a_o),
    .fwd_valid_b_o                  (fwd_valid_b_o),
    .fwd_data_a_o                   (fwd_data_a_o),
    .fwd_data_b_o                   (fwd_data_b_o),
    .outstanding_load_wb_o          (outstanding_load_wb_o),
    .outstanding_store_wb_o         (outstanding_store_wb_o),
    .rf_waddr_wb_o                  (rf_waddr_wb_o),
    .rf_wdata_wb_o                  (rf_wdata_wb_o),
    .rf_we_wb_o                     (rf_we_wb_o),
    .fp_rf_we_wb_o                  (fp_rf_we_wb_o),
    .pc_wb_o                        (pc_wb_o),
    .instr_done_wb_o                (instr_done_wb_o),
    .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
    .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic expect_ret(input logic we, input logic fpwe, input logic [4:0] wa,
                            input logic [31:0] wd, input logic perf, input logic perfc);
    exp_t e;
    e.we = we; e.fpwe = fpwe; e.waddr = wa; e.wdata = wd; e.perf = perf; e.perfc = perfc;
    exp_q.push_back(e);
  endtask

  task automatic drive_push(input wb_instr_type_e t, input logic [4:0] wa, input logic [31:0] wd,
                            input logic we, input logic fp, input logic [31:0] pc,
                            input logic comp, input logic cnt);
    en_wb_i                  = 1'b1;
    instr_type_wb_i          = t;
    rf_waddr_id_i            = wa;
    rf_wdata_id_i            = wd;
    rf_we_id_i               = we;
    fp_rf_we_id_i            = fp;
    pc_id_i                  = pc;
    instr_is_compressed_id_i = comp;
    instr_perf_count_id_i    = cnt;
  endtask

  task automatic drive_resp(input logic [31:0] d, input logic err);
    lsu_resp_valid_i = 1'b1;
    lsu_resp_err_i   = err;
    rf_wdata_lsu_i   = d;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    en_wb_i          = 1'b0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_err_i   = 1'b0;
    rf_wdata_lsu_i   = '0;
  endtask

  // Retire monitor: every retire must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (instr_done_wb_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected: got waddr=%0d pc=%h, want no retire", rf_waddr_wb_o, pc_wb_o);
      end else begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a.we    = rf_we_wb_o;
        a.fpwe  = fp_rf_we_wb_o;
        a.waddr = (e.we | e.fpwe) ? rf_waddr_wb_o : e.waddr;
        a.wdata = (e.we | e.fpwe) ? rf_wdata_wb_o : e.wdata;
        a.perf  = perf_instr_ret_wb_o;
        a.perfc = perf_instr_ret_compressed_wb_o;
        if (a !== e) begin
          bad++;
          $display("FAIL retire: got we=%b fpwe=%b waddr=%0d wdata=%h perf=%b perfc=%b want we=%b fpwe=%b waddr=%0d wdata=%h perf=%b perfc=%b",
                   a.we, a.fpwe, a.waddr, a.wdata, a.perf, a.perfc,
                   e.we, e.fpwe, e.waddr, e.wdata, e.perf, e.perfc);
        end
      end
    end
    if (rst_ni && lsu_resp_valid_i) begin
      assert (outstanding_load_wb_o || outstanding_store_wb_o)
        else $error("lsu response with no outstanding load/store");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    en_wb_i = 1'b0; instr_type_wb_i = WB_INSTR_OTHER; pc_id_i = '0;
    instr_is_compressed_id_i = 1'b0; instr_perf_count_id_i = 1'b0;
    rf_waddr_id_i = '0; rf_wdata_id_i = '0; rf_we_id_i = 1'b0; fp_rf_we_id_i = 1'b0;
    lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0; rf_wdata_lsu_i = '0;
    rf_raddr_a_i = '0; rf_raddr_b_i = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(ready_wb_o), 32'd1);
    chk("rst_pc", pc_wb_o, 32'd0);
    chk("rst_we", 32'({rf_we_wb_o, fp_rf_we_wb_o, instr_done_wb_o}), 32'd0);
    chk("rst_wdata", rf_wdata_wb_o, 32'd0);
    chk("rst_outstanding", 32'({outstanding_load_wb_o, outstanding_store_wb_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Back-to-back OTHER
    drive_push(WB_INSTR_OTHER, 5'd1, 32'd5, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd1, 32'd5, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("b2b_ready0", 32'(ready_wb_o), 32'd1);
    tick();
    drive_push(WB_INSTR_OTHER, 5'd2, 32'd7, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd2, 32'd7, 1'b1, 1'b1);
    @(negedge clk_i);
    chk("b2b_ready1", 32'(ready_wb_o), 32'd1);
    chk("b2b_done1", 32'({instr_done_wb_o, rf_we_wb_o, rf_waddr_wb_o}), 32'b1_1_00001);
    tick();
    @(negedge clk_i);
    chk("b2b_pc2", pc_wb_o, 32'h104);
    tick();
    @(negedge clk_i);
    chk("b2b_pc_empty", pc_wb_o, 32'd0);

    // Fill with loads and stall
    drive_push(WB_INSTR_LOAD, 5'd3, 32'd0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd3, 32'hAA, 1'b1, 1'b0);
    tick();
    drive_push(WB_INSTR_LOAD, 5'd4, 32'd0, 1'b1, 1'b0, 32'h204, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd4, 32'hBB, 1'b1, 1'b0);
    tick();
    drive_push(WB_INSTR_LOAD, 5'd12, 32'd0, 1'b1, 1'b0, 32'h208, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd12, 32'hCC, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("fill_ready_2of3", 32'(ready_wb_o), 32'd1);
    tick();
    rf_raddr_a_i = 5'd4;
    @(negedge clk_i);
    chk("fill_ready_full", 32'(ready_wb_o), 32'd0);
    chk("fill_out_load", 32'(outstanding_load_wb_o), 32'd1);
    chk("fill_pc_head", pc_wb_o, 32'h200);
    chk("fill_hazard_a", 32'({hazard_a_o, fwd_valid_a_o}), 32'b10);
    tick();
    rf_raddr_a_i = 5'd0;
    drive_resp(32'hAA, 1'b0);
    @(negedge clk_i);
    chk("fill_ready_resp1", 32'(ready_wb_o), 32'd1);
    chk("fill_lsu_comb", rf_wdata_wb_o, 32'hAA);
    tick();
    drive_resp(32'hBB, 1'b0);
    @(negedge clk_i);
    chk("fill_ready_resp2", 32'(ready_wb_o), 32'd1);
    tick();
    drive_resp(32'hCC, 1'b0);
    tick();
    @(negedge clk_i);
    chk("fill_drained", 32'({outstanding_load_wb_o, ready_wb_o}), 32'b01);

    // Full queue: pop and push in the same cycle
    drive_push(WB_INSTR_LOAD, 5'd10, 32'd0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd10, 32'h11, 1'b1, 1'b0);
    tick();
    drive_push(WB_INSTR_STORE, 5'd0, 32'd0, 1'b0, 1'b0, 32'h304, 1'b0, 1'b1);
    expect_ret(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    drive_push(WB_INSTR_LOAD, 5'd13, 32'd0, 1'b1, 1'b0, 32'h308, 1'b1, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd13, 32'h33, 1'b1, 1'b1);
    tick();
    drive_push(WB_INSTR_OTHER, 5'd11, 32'h22, 1'b1, 1'b0, 32'h30C, 1'b0, 1'b1);
    drive_resp(32'h11, 1'b0);
    expect_ret(1'b1, 1'b0, 5'd11, 32'h22, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("full_pushpop_ready", 32'(ready_wb_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk("full_still_full", 32'(ready_wb_o), 32'd0);
    chk("full_out_store", 32'(outstanding_store_wb_o), 32'd1);
    tick();
    drive_resp(32'd0, 1'b0);
    tick();
    drive_resp(32'h33, 1'b0);
    tick();
    tick();

    // Forwarding priority behind a blocking load
    drive_push(WB_INSTR_LOAD, 5'd20, 32'd0, 1'b1, 1'b0, 32'h400, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd20, 32'h44, 1'b1, 1'b0);
    tick();
    drive_push(WB_INSTR_OTHER, 5'd5, 32'd1, 1'b1, 1'b0, 32'h404, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd5, 32'd1, 1'b1, 1'b0);
    tick();
    drive_push(WB_INSTR_OTHER, 5'd5, 32'd2, 1'b1, 1'b0, 32'h408, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd5, 32'd2, 1'b1, 1'b0);
    tick();
    rf_raddr_a_i = 5'd5;
    rf_raddr_b_i = 5'd0;
    @(negedge clk_i);
    chk("fwd_a_valid", 32'({hazard_a_o, fwd_valid_a_o}), 32'b01);
    chk("fwd_a_data", fwd_data_a_o, 32'd2);
    chk("fwd_b_zero", 32'({hazard_b_o, fwd_valid_b_o}), 32'd0);
    chk("fwd_b_data", fwd_data_b_o, 32'd0);
    tick();
    drive_resp(32'h44, 1'b0);
    drive_push(WB_INSTR_LOAD, 5'd5, 32'd0, 1'b1, 1'b0, 32'h40C, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd5, 32'h55, 1'b1, 1'b0);
    tick();
    @(negedge clk_i);
    chk("fwd_load_hazard", 32'({hazard_a_o, fwd_valid_a_o}), 32'b10);
    tick();
    @(negedge clk_i);
    chk("fwd_load_hazard2", 32'({hazard_a_o, fwd_valid_a_o}), 32'b10);
    tick();
    drive_resp(32'h55, 1'b0);
    tick();
    rf_raddr_a_i = 5'd0;

    // Load error
    drive_push(WB_INSTR_LOAD, 5'd6, 32'd0, 1'b1, 1'b0, 32'h500, 1'b0, 1'b1);
    expect_ret(1'b0, 1'b0, 5'd6, 32'd0, 1'b0, 1'b0);
    tick();
    drive_resp(32'hDEAD, 1'b1);
    @(negedge clk_i);
    chk("lerr_done", 32'(instr_done_wb_o), 32'd1);
    chk("lerr_we_perf", 32'({rf_we_wb_o, perf_instr_ret_wb_o}), 32'd0);
    tick();

    // FP routing
    drive_push(WB_INSTR_OTHER, 5'd9, 32'h99, 1'b1, 1'b1, 32'h600, 1'b0, 1'b1);
    expect_ret(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
    tick();
    rf_raddr_a_i = 5'd9;
    @(negedge clk_i);
    chk("fp_route", 32'({fp_rf_we_wb_o, rf_we_wb_o}), 32'b10);
    chk("fp_no_fwd", 32'({hazard_a_o, fwd_valid_a_o}), 32'd0);
    tick();
    rf_raddr_a_i = 5'd0;

    // Reset with pending entries discards them
    drive_push(WB_INSTR_LOAD, 5'd7, 32'd0, 1'b1, 1'b0, 32'h700, 1'b0, 1'b1);
    tick();
    drive_push(WB_INSTR_LOAD, 5'd8, 32'd0, 1'b1, 1'b0, 32'h704, 1'b0, 1'b1);
    tick();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mrst_ready", 32'(ready_wb_o), 32'd1);
    chk("mrst_pc", pc_wb_o, 32'd0);
    chk("mrst_no_write", 32'({rf_we_wb_o, fp_rf_we_wb_o, outstanding_load_wb_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mrst_after", 32'({ready_wb_o, outstanding_load_wb_o}), 32'b10);
    chk("mrst_after_pc", pc_wb_o, 32'd0);
    tick();
    drive_push(WB_INSTR_OTHER, 5'd1, 32'd3, 1'b1, 1'b0, 32'h800, 1'b0, 1'b1);
    expect_ret(1'b1, 1'b0, 5'd1, 32'd3, 1'b1, 1'b0);
    tick();
    tick();
    @(negedge clk_i);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
